buyruk_yukleyici: RTL
=====================

// Module: buyruk_yukleyici
// PURPOSE
//  Writer side of the instruction memory: receives a program as a byte stream over a
//  valid/ready handshake and writes it word by word into buyruk_bellegi's write port.
//  Holds the core (islemcib) in reset while loading and releases it once the last word
//  is written. Sits in the top-level wrapper between the external loader link and the
//  instruction memory.
// PARAMETERS
//  BASLANGIC_ADRES  32'h0000_0000  byte address of the first instruction word
//  MAKS_BUYRUK      1024           instruction memory capacity in 32-bit words
// PORTS
//  clk             in   1   clock, all logic on rising edge
//  rst             in   1   synchronous, active-high reset
//  bayt_gecerli    in   1   source has a byte on bayt
//  bayt            in   8   incoming byte
//  bayt_hazir      out  1   block can accept a byte this cycle
//  yaz_aktif       out  1   one-cycle instruction-memory write strobe
//  yaz_adres       out  32  byte address of the word being written
//  yaz_veri        out  32  word being written
//  cekirdek_rst    out  1   reset to core, 1 while loading
//  yukleme_bitti   out  1   load complete, core released
//  hata            out  1   word count exceeded MAKS_BUYRUK
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high. State=SAYI_AL, byte/word counters=0,
//   bayt_hazir=1, yaz_aktif=0, yaz_adres=BASLANGIC_ADRES, yaz_veri=0,
//   cekirdek_rst=1, yukleme_bitti=0, hata=0.
//  Transfer: a byte is taken only when bayt_gecerli && bayt_hazir are both high at a
//   rising edge. bayt_gecerli low inserts any number of idle cycles, with no effect.
//  Stream format, little-endian throughout:
//   - 4 bytes: word count N.
//   - Then N words of 4 bytes each. Byte k of a word fills bits [8k+7:8k].
//  States:
//   SAYI_AL: bayt_hazir=1; collect the 4 count bytes. After the 4th byte:
//    - N==0 -> BITTI.
//    - N>MAKS_BUYRUK -> HATA.
//    - otherwise -> VERI_AL.
//   VERI_AL: bayt_hazir=1; collect 4 bytes into the word register.
//    The 4th byte is accepted at edge t -> YAZ.
//   YAZ: lasts exactly one cycle (t..t+1); bayt_hazir=0; yaz_aktif=1.
//    - yaz_veri = the assembled word.
//    - yaz_adres = BASLANGIC_ADRES + 4*i, where i is the 0-based word index, mod 2^32.
//    - Then i+1: if i+1==N -> BITTI, else -> VERI_AL.
//   BITTI: bayt_hazir=0, cekirdek_rst=0, yukleme_bitti=1. Further bytes are ignored.
//    The state persists until rst.
//   HATA: bayt_hazir=0, cekirdek_rst=1, hata=1, no writes. The state persists until rst.
//  Latency:
//   - yaz_aktif is high in the cycle after the 4th byte of each word.
//   - cekirdek_rst falls in the cycle after the last YAZ cycle. For N==0 it falls in the
//     cycle after the 4th count byte.
//  yaz_aktif is never high outside YAZ. yaz_adres and yaz_veri hold their values
//   outside YAZ.
//  N==MAKS_BUYRUK is legal. The last address is BASLANGIC_ADRES + 4*(MAKS_BUYRUK-1).
//  Reset at any point, including mid-word or during YAZ:
//   - any partial word is discarded and no write is issued;
//   - the block returns to SAYI_AL and cekirdek_rst reasserts immediately.
//  All outputs are registered.
// TESTING
//  1. rst, then stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00 (word 1 = 0x00100093),
//   bayt_gecerli always 1.
//   -> writes (0x0, 0x00000013) then (0x4, 0x00100093), each yaz_aktif 1 cycle;
//   -> bayt_hazir=0 during each YAZ;
//   -> cekirdek_rst=0 and yukleme_bitti=1 from the cycle after the 2nd write.
//  2. Count 00 00 00 00.
//   -> no yaz_aktif;
//   -> cekirdek_rst=0 and yukleme_bitti=1 in the cycle after the 4th byte;
//   -> extra bytes are not accepted (bayt_hazir=0).
//  3. MAKS_BUYRUK=4, count 05 00 00 00.
//   -> hata=1, cekirdek_rst=1, bayt_hazir=0, no writes, state held until rst.
//  4. Case 1 with random 0-3 cycle gaps on bayt_gecerli.
//   -> identical writes and addresses; bytes seen while bayt_hazir=0 are not consumed.
//  5. BASLANGIC_ADRES=32'h100, count 1, word DEADBEEF sent as EF BE AD DE.
//   -> one write (0x100, 0xDEADBEEF).
//  6. Case 1, rst asserted after 2 bytes of word 1, then the full case-1 stream resent.
//   -> the interrupted word is never written;
//   -> after the resend, writes occur at 0x0 and 0x4 with the case-1 data.

Source files
------------

// File: rtl/buyruk_yukleyici_if.sv
// ----------------------------------------------------------------------------
// buyruk_yukleyici_if
//  Groups the loader's byte-stream handshake and the instruction-memory write
//  port into one bundle.
//  Signals:
//   bayt_gecerli  source -> loader   source has a byte on bayt
//   bayt[7:0]     source -> loader   incoming byte
//   bayt_hazir    loader -> source   loader accepts a byte this cycle
//   yaz_aktif     loader -> memory   one-cycle write strobe
//   yaz_adres     loader -> memory   byte address of the word being written
//   yaz_veri      loader -> memory   word being written
//   cekirdek_rst  loader -> core     core reset, 1 while loading
//   yukleme_bitti loader -> system   load complete
//   hata          loader -> system   word count exceeded capacity
//  Modports:
//   slave   the loader block itself
//   master  the environment around it (byte source, memory, core)
// ----------------------------------------------------------------------------
interface buyruk_yukleyici_if;
    logic        bayt_gecerli;
    logic [7:0]  bayt;
    logic        bayt_hazir;
    logic        yaz_aktif;
    logic [31:0] yaz_adres;
    logic [31:0] yaz_veri;
    logic        cekirdek_rst;
    logic        yukleme_bitti;
    logic        hata;

    modport slave (
        input  bayt_gecerli,
        input  bayt,
        output bayt_hazir,
        output yaz_aktif,
        output yaz_adres,
        output yaz_veri,
        output cekirdek_rst,
        output yukleme_bitti,
        output hata
    );

    modport master (
        output bayt_gecerli,
        output bayt,
        input  bayt_hazir,
        input  yaz_aktif,
        input  yaz_adres,
        input  yaz_veri,
        input  cekirdek_rst,
        input  yukleme_bitti,
        input  hata
    );
endinterface

// File: rtl/buyruk_yukleyici.sv
// ----------------------------------------------------------------------------
// buyruk_yukleyici
//  Writer side of the instruction memory. Receives a little-endian byte stream
//  (4-byte word count N, then N 4-byte words) over a valid/ready handshake and
//  writes each word into the instruction memory with a one-cycle strobe. Keeps
//  the core in reset while loading and releases it after the last write.
//  Parameters:
//   BASLANGIC_ADRES  byte address of the first instruction word
//   MAKS_BUYRUK      instruction memory capacity in 32-bit words
//  Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset
//   io_bus  slave modport of buyruk_yukleyici_if (handshake, write port,
//           core reset and status)
//  All outputs are registered.
// ----------------------------------------------------------------------------
module buyruk_yukleyici #(
    parameter logic [31:0] BASLANGIC_ADRES = 32'h0000_0000,
    parameter int unsigned MAKS_BUYRUK     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    buyruk_yukleyici_if.slave     io_bus
);

    localparam logic [31:0] MAKS = 32'(MAKS_BUYRUK);

    typedef enum logic [2:0] {
        SAYI_AL,
        VERI_AL,
        YAZ,
        BITTI,
        HATA
    } durum_t;

    // State and datapath registers
    durum_t      r_durum;
    logic [1:0]  r_bayt_say;   // byte position within the current 4-byte group
    logic [31:0] r_sayi;       // word count N (shift-assembled)
    logic [31:0] r_kelime;     // word being assembled
    logic [31:0] r_indeks;     // 0-based index of the next word to write

    // Registered outputs
    logic        r_hazir;
    logic        r_yaz_aktif;
    logic [31:0] r_yaz_adres;
    logic [31:0] r_yaz_veri;
    logic        r_cek_rst;
    logic        r_bitti;
    logic        r_hata;

    // Next-state / next-value signals
    durum_t      w_sonraki;
    logic [1:0]  w_bayt_say_d;
    logic [31:0] w_sayi_d;
    logic [31:0] w_kelime_d;
    logic [31:0] w_indeks_d;
    logic [31:0] w_yaz_adres_d;
    logic [31:0] w_yaz_veri_d;

    logic        w_kabul;
    logic [31:0] w_sayi_yeni;
    logic [31:0] w_kelime_yeni;
    logic [31:0] w_indeks_art;

    assign w_kabul = io_bus.bayt_gecerli && r_hazir;

    // Bytes arrive least-significant first, so shifting each new byte in at
    // the top leaves byte k in bits [8k+7:8k] after the 4th byte.
    assign w_sayi_yeni   = {io_bus.bayt, r_sayi[31:8]};
    assign w_kelime_yeni = {io_bus.bayt, r_kelime[31:8]};
    assign w_indeks_art  = r_indeks + 32'd1;

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_sonraki     = r_durum;
        w_bayt_say_d  = r_bayt_say;
        w_sayi_d      = r_sayi;
        w_kelime_d    = r_kelime;
        w_indeks_d    = r_indeks;
        w_yaz_adres_d = r_yaz_adres;
        w_yaz_veri_d  = r_yaz_veri;

        unique case (r_durum)
            SAYI_AL: begin
                if (w_kabul) begin
                    w_sayi_d     = w_sayi_yeni;
                    w_bayt_say_d = r_bayt_say + 2'd1;
                    if (r_bayt_say == 2'd3) begin
                        if (w_sayi_yeni == 32'd0) begin
                            w_sonraki = BITTI;
                        end else if (w_sayi_yeni > MAKS) begin
                            w_sonraki = HATA;
                        end else begin
                            w_sonraki = VERI_AL;
                        end
                    end
                end
            end

            VERI_AL: begin
                if (w_kabul) begin
                    w_kelime_d   = w_kelime_yeni;
                    w_bayt_say_d = r_bayt_say + 2'd1;
                    if (r_bayt_say == 2'd3) begin
                        w_sonraki     = YAZ;
                        w_yaz_veri_d  = w_kelime_yeni;
                        // Address wraps modulo 2^32 by truncation.
                        w_yaz_adres_d = BASLANGIC_ADRES + {r_indeks[29:0], 2'b00};
                    end
                end
            end

            YAZ: begin
                w_indeks_d = w_indeks_art;
                w_sonraki  = (w_indeks_art == r_sayi) ? BITTI : VERI_AL;
            end

            BITTI: w_sonraki = BITTI;
            HATA:  w_sonraki = HATA;

            default: w_sonraki = SAYI_AL;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // reflects the state that is current during the cycle it is seen.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_durum     <= SAYI_AL;
            r_bayt_say  <= 2'd0;
            r_sayi      <= 32'd0;
            r_kelime    <= 32'd0;
            r_indeks    <= 32'd0;
            r_hazir     <= 1'b1;
            r_yaz_aktif <= 1'b0;
            r_yaz_adres <= BASLANGIC_ADRES;
            r_yaz_veri  <= 32'd0;
            r_cek_rst   <= 1'b1;
            r_bitti     <= 1'b0;
            r_hata      <= 1'b0;
        end else begin
            r_durum     <= w_sonraki;
            r_bayt_say  <= w_bayt_say_d;
            r_sayi      <= w_sayi_d;
            r_kelime    <= w_kelime_d;
            r_indeks    <= w_indeks_d;
            r_hazir     <= (w_sonraki == SAYI_AL) || (w_sonraki == VERI_AL);
            r_yaz_aktif <= (w_sonraki == YAZ);
            r_yaz_adres <= w_yaz_adres_d;
            r_yaz_veri  <= w_yaz_veri_d;
            r_cek_rst   <= (w_sonraki != BITTI);
            r_bitti     <= (w_sonraki == BITTI);
            r_hata      <= (w_sonraki == HATA);
        end
    end

    assign io_bus.bayt_hazir    = r_hazir;
    assign io_bus.yaz_aktif     = r_yaz_aktif;
    assign io_bus.yaz_adres     = r_yaz_adres;
    assign io_bus.yaz_veri      = r_yaz_veri;
    assign io_bus.cekirdek_rst  = r_cek_rst;
    assign io_bus.yukleme_bitti = r_bitti;
    assign io_bus.hata          = r_hata;

endmodule
